// File: rtl/pe_mac_drain_if.sv
// Signal bundle for one systolic PE: operand forwarding, accumulator control,
// result drain chain and status flags.
interface pe_mac_drain_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 40
);
  logic [DWIDTH-1:0] west_data;
  logic              west_valid;
  logic              west_last;
  logic [DWIDTH-1:0] north_data;
  logic              north_valid;
  logic [DWIDTH-1:0] east_data;
  logic              east_valid;
  logic              east_last;
  logic [DWIDTH-1:0] south_data;
  logic              south_valid;
  logic              acc_clr;
  logic [AWIDTH-1:0] drain_in_data;
  logic              drain_in_valid;
  logic              drain_in_last;
  logic              drain_in_ready;
  logic [AWIDTH-1:0] drain_out_data;
  logic              drain_out_valid;
  logic              drain_out_last;
  logic              drain_out_ready;
  logic              sat_flag;
  logic              ovr_err;

  modport slave (
    input  west_data, west_valid, west_last, north_data, north_valid, acc_clr,
           drain_in_data, drain_in_valid, drain_in_last, drain_out_ready,
    output east_data, east_valid, east_last, south_data, south_valid,
           drain_in_ready, drain_out_data, drain_out_valid, drain_out_last,
           sat_flag, ovr_err
  );

  modport master (
    output west_data, west_valid, west_last, north_data, north_valid, acc_clr,
           drain_in_data, drain_in_valid, drain_in_last, drain_out_ready,
    input  east_data, east_valid, east_last, south_data, south_valid,
           drain_in_ready, drain_out_data, drain_out_valid, drain_out_last,
           sat_flag, ovr_err
  );
endinterface

// File: rtl/pe_mac_drain.sv
// Systolic-array PE: forwards operands east/south, accumulates products per tile,
// and drains each finished tile result down a shared valid/ready column chain.
module pe_mac_drain #(
  parameter int DWIDTH    = 16,
  parameter int AWIDTH    = 40,
  parameter int SIGNED    = 1,
  parameter int SATURATE  = 1,
  parameter int PIPE_MULT = 1,
  parameter int CHAIN_TOP = 0
) (
  input  logic            clk,
  input  logic            rst,
  pe_mac_drain_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, OWN, PASS} drain_state_t;

  localparam logic [AWIDTH-1:0] SMAX = {1'b0, {(AWIDTH-1){1'b1}}};
  localparam logic [AWIDTH-1:0] SMIN = {1'b1, {(AWIDTH-1){1'b0}}};

  function automatic logic [AWIDTH-1:0] ext_product(input logic [DWIDTH-1:0] a,
                                                    input logic [DWIDTH-1:0] b);
    logic signed [2*DWIDTH-1:0] sa, sb, sp;
    logic        [2*DWIDTH-1:0] ua, ub, up;
    sa = {{DWIDTH{a[DWIDTH-1]}}, a};
    sb = {{DWIDTH{b[DWIDTH-1]}}, b};
    sp = sa * sb;
    ua = {{DWIDTH{1'b0}}, a};
    ub = {{DWIDTH{1'b0}}, b};
    up = ua * ub;
    if (SIGNED != 0) return AWIDTH'(sp);
    else             return AWIDTH'(up);
  endfunction

  // Returns {overflow, result}; result is clamped when saturation is enabled.
  function automatic logic [AWIDTH:0] sat_add(input logic [AWIDTH-1:0] a,
                                              input logic [AWIDTH-1:0] b);
    logic signed [AWIDTH:0] ext;
    logic                   ovf;
    logic [AWIDTH-1:0]      res;
    if (SIGNED != 0) begin
      ext = $signed({a[AWIDTH-1], a}) + $signed({b[AWIDTH-1], b});
      ovf = ext[AWIDTH] ^ ext[AWIDTH-1];
    end else begin
      ext = $signed({1'b0, a} + {1'b0, b});
      ovf = ext[AWIDTH];
    end
    res = ext[AWIDTH-1:0];
    if (ovf && (SATURATE != 0)) begin
      if (SIGNED != 0) res = ext[AWIDTH] ? SMIN : SMAX;
      else             res = '1;
    end
    return {ovf, res};
  endfunction

  // Stage p0: operand forwarding and product formation
  logic              fire_p0;
  logic [AWIDTH-1:0] prod_p0;

  assign fire_p0 = bus.west_valid & bus.north_valid;
  assign prod_p0 = ext_product(bus.west_data, bus.north_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.east_data   <= '0;
      bus.east_valid  <= 1'b0;
      bus.east_last   <= 1'b0;
      bus.south_data  <= '0;
      bus.south_valid <= 1'b0;
    end else begin
      bus.east_data   <= bus.west_data;
      bus.east_valid  <= bus.west_valid;
      bus.east_last   <= bus.west_last;
      bus.south_data  <= bus.north_data;
      bus.south_valid <= bus.north_valid;
    end
  end

  // Stage p1: registered product (bypassed when PIPE_MULT is 0)
  logic [AWIDTH-1:0] prod_p1;
  logic              vld_p1;
  logic              last_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      prod_p1 <= prod_p0;
      vld_p1  <= fire_p0 & ~bus.acc_clr;
      last_p1 <= fire_p0 & bus.west_last & ~bus.acc_clr;
    end
  end

  logic [AWIDTH-1:0] add_prod;
  logic              add_vld;
  logic              add_last;

  assign add_prod = (PIPE_MULT != 0) ? prod_p1 : prod_p0;
  assign add_vld  = (PIPE_MULT != 0) ? vld_p1  : fire_p0;
  assign add_last = (PIPE_MULT != 0) ? last_p1 : bus.west_last;

  // Stage p2: accumulate, tile completion and result drain
  logic [AWIDTH-1:0] acc_p2;
  logic [AWIDTH-1:0] res_p2;
  logic [AWIDTH:0]   sum_ext;
  logic              sat_p2;
  logic              ovr_p2;
  logic              cmpl;
  logic              drain_done;
  logic              load_ok;
  drain_state_t      state;

  assign sum_ext = sat_add(acc_p2, add_prod);
  assign cmpl    = add_vld & add_last & ~bus.acc_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p2 <= '0;
      sat_p2 <= 1'b0;
    end else if (bus.acc_clr) begin
      acc_p2 <= '0;
      sat_p2 <= 1'b0;
    end else if (add_vld) begin
      acc_p2 <= add_last ? '0 : sum_ext[AWIDTH-1:0];
      if (sum_ext[AWIDTH]) sat_p2 <= 1'b1;
    end
  end

  // A finishing transfer frees the output register on the same edge a new result lands.
  assign drain_done = ((state == OWN) && bus.drain_out_ready && (CHAIN_TOP != 0)) ||
                      ((state == PASS) && bus.drain_in_valid && bus.drain_out_ready &&
                       bus.drain_in_last);
  assign load_ok    = (state == IDLE) || drain_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      res_p2 <= '0;
      ovr_p2 <= 1'b0;
    end else if (cmpl && load_ok) begin
      res_p2 <= sum_ext[AWIDTH-1:0];
      state  <= OWN;
    end else begin
      if (cmpl) ovr_p2 <= 1'b1;
      case (state)
        OWN:     if (bus.drain_out_ready) state <= (CHAIN_TOP != 0) ? IDLE : PASS;
        PASS:    if (drain_done) state <= IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.drain_out_data  = '0;
    bus.drain_out_valid = 1'b0;
    bus.drain_out_last  = 1'b0;
    bus.drain_in_ready  = 1'b0;
    case (state)
      OWN: begin
        bus.drain_out_data  = res_p2;
        bus.drain_out_valid = 1'b1;
        bus.drain_out_last  = (CHAIN_TOP != 0);
      end
      PASS: begin
        bus.drain_out_data  = bus.drain_in_data;
        bus.drain_out_valid = bus.drain_in_valid;
        bus.drain_out_last  = bus.drain_in_last;
        bus.drain_in_ready  = bus.drain_out_ready;
      end
      default: ;
    endcase
  end

  assign bus.sat_flag = sat_p2;
  assign bus.ovr_err  = ovr_p2;

endmodule
